serial_adder_responder: RTL



---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/serial_adder_full_adder.sv | 14 +
 rtl/serial_adder_responder.sv | 119 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder responder.
// State encoding and default operand width.
package serial_adder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ADD  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell used by the serial datapath.
// Purely combinational.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_responder.sv
// Bit-serial adder, LSB first, one full-adder cell plus carry flop.
// Responds to a start/done handshake with registered sum and c_out.
module serial_adder_responder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A_data,
  input  logic [WIDTH-1:0] B_data,
  input  logic             c_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  // one extra bit so the counter never wraps at WIDTH=16
  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    count;
  logic             bit_s;
  logic             bit_c;
  logic             accept;
  logic             last;

  full_adder_cell u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (bit_s),
    .cout (bit_c)
  );

  assign accept   = start &
                    ((state == ST_IDLE) |
                     (state == ST_DONE));
  assign last     = (state == ST_ADD) &
                    (count == CW'(WIDTH - 1));
  assign res_next = {bit_s, res_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (start) next_state = ST_ADD;
      end
      ST_ADD: begin
        if (last) next_state = ST_DONE;
      end
      ST_DONE: begin
        if (start) next_state = ST_ADD;
        else       next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (1'b1)
      (state == ST_IDLE): ready = 1'b1;
      (state == ST_ADD):  busy  = 1'b1;
      (state == ST_DONE): begin
        ready = 1'b1;
        done  = 1'b1;
      end
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      count  <= '0;
      sum    <= '0;
      c_out  <= 1'b0;
    end else if (accept) begin
      a_sh   <= A_data;
      b_sh   <= B_data;
      carry  <= c_in;
      count  <= '0;
    end else if (state == ST_ADD) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      carry  <= bit_c;
      res_sh <= res_next;
      count  <= count + 1'b1;
      if (last) begin
        sum   <= res_next;
        c_out <= bit_c;
      end
    end
  end

endmodule
